// File: rtl/frame_reader_pkg.sv
// Shared RAM constants used by the port-B frame reader.
// Word width and byte-lane count of the 16-bit dual-port RAM.
package frame_reader_pkg;

    localparam int WORD_W     = 16;
    localparam int BYTE_LANES = 2;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with registered status flags.
// Storage is cleared on reset so the head word reads as zero.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (do_pop) rd_q <= rd_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/frame_reader.sv
// Streams a frame of consecutive words from RAM port B onto a
// valid/ready interface, buffering through a small FIFO.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int DEPTH         = 16384,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   frame_words,
    output logic [ADDRESS_WIDTH-1:0] addr_b,
    input  logic [WORD_W-1:0]        q_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = WORD_W + 1;
    localparam logic [CW:0]              FIFO_CAP = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   REM_ONE  = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] held_q, held_d;
    logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
    logic                     inflight_q, inflight_last_q;
    logic                     issue, pop, final_rd;
    logic                     fifo_full, fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic [FW-1:0]            fifo_dout;
    logic [CW:0]              occ;

    // Words buffered plus the read whose data lands next cycle.
    assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign pop      = out_valid & out_ready;
    assign final_rd = issue & (rem_q == REM_ONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (final_rd) state_d = S_DRAIN;
            S_DRAIN: if (pop && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                issue = (occ < FIFO_CAP) && !fifo_full;
                busy  = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            default: begin
                issue = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        held_d = held_q;
        if (state_q == S_IDLE && start) begin
            addr_d = base_addr;
            rem_d  = (frame_words == '0) ? REM_ONE : frame_words;
        end else if (issue) begin
            addr_d = addr_q + ADDR_ONE;
            rem_d  = rem_q - REM_ONE;
            held_d = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            held_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            held_q          <= held_d;
            rem_q           <= rem_d;
            inflight_q      <= issue;
            inflight_last_q <= final_rd;
        end
    end

    assign addr_b = issue ? addr_q : held_q;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, q_b}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_dout[WORD_W-1:0];
    assign out_last  = fifo_dout[WORD_W] & out_valid;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: table of frames plus random frames,
// checked against a RAM-contents scoreboard.
module tb_frame_reader;

    localparam int DEPTH = 16384;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   frame_words;
    logic [AW-1:0] addr_b;
    logic [15:0]   q_b;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_last;
    logic          busy;

    logic [15:0] ram [DEPTH];

    int tests = 0;
    int fails = 0;

    frame_reader #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .frame_words (frame_words),
        .addr_b      (addr_b),
        .q_b         (q_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) q_b <= ram[addr_b];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int base;
        int words;
        int pct;
        int ign_at;
        int exp_n;
        int exp_cycles;
    } vec_t;

    // Runs one frame; cycle 1 is the cycle after start is sampled.
    task automatic run_frame(input int base, input int words, input int pct,
                             input int ign_at, input int exp_n,
                             input int exp_cycles);
        int n;
        int got;
        int cyc;
        int first;
        int budget;
        bit pv, pr, saw500, done;
        logic [15:0] pd;
        logic pl;
        n      = (words == 0) ? 1 : words;
        got    = 0;
        first  = -1;
        pv     = 0;
        pr     = 0;
        pd     = '0;
        pl     = 0;
        saw500 = 0;
        done   = 0;
        budget = 30 * n + 200;
        @(negedge clk);
        base_addr   = AW'(base);
        frame_words = (AW+1)'(words);
        start       = 1'b1;
        out_ready   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < budget) begin
            if (cyc == ign_at) begin
                start       = 1'b1;
                base_addr   = AW'(500);
                frame_words = (AW+1)'(3);
            end else begin
                start = 1'b0;
            end
            out_ready = ($urandom_range(99) < pct);
            if (ign_at > 0 && busy && addr_b == AW'(500)) saw500 = 1;
            if (cyc == 1) chk("first_addr", 32'(addr_b), 32'(base % DEPTH));
            if (pv && !pr) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", {16'd0, out_data}, {16'd0, pd});
                chk("stall_last", 32'(out_last), 32'(pl));
            end
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                if (got >= n) begin
                    chk("extra_word", 32'(got), 32'(n - 1));
                end else begin
                    chk("data", {16'd0, out_data},
                        {16'd0, ram[(base + got) % DEPTH]});
                    chk("last", 32'(out_last), 32'(got == n - 1));
                end
                got++;
            end
            if (!busy) begin
                done = 1;
            end else begin
                pv = out_valid;
                pr = out_ready;
                pd = out_data;
                pl = out_last;
                @(negedge clk);
                cyc++;
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk("frame_done", 32'(done), 32'd1);
        chk("word_count", 32'(got), 32'(exp_n));
        if (exp_cycles > 0) begin
            chk("busy_fall_cycle", 32'(cyc), 32'(exp_cycles));
            chk("first_word_cycle", 32'(first), 32'd3);
        end
        if (ign_at > 0) chk("no_read_500", 32'(saw500), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int got;
        for (int i = 0; i < DEPTH; i++) ram[i] = 16'(i) ^ 16'hC35A;
        for (int i = 0; i < 4; i++) ram[100 + i] = 16'hA000 + 16'(i);

        vecs.push_back('{100,         4,     100, 0, 4,     7});
        vecs.push_back('{DEPTH - 2,   4,     100, 0, 4,     7});
        vecs.push_back('{1000,        16,    30,  0, 16,    0});
        vecs.push_back('{3000,        6,     100, 2, 6,     9});
        vecs.push_back('{50,          1,     100, 0, 1,     4});
        vecs.push_back('{60,          0,     100, 0, 1,     4});
        vecs.push_back('{DEPTH - 3,   20,    45,  0, 20,    0});
        vecs.push_back('{5,           DEPTH, 100, 0, DEPTH, DEPTH + 3});

        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        frame_words = '0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_addr", 32'(addr_b), 32'd0);

        foreach (vecs[i])
            run_frame(vecs[i].base, vecs[i].words, vecs[i].pct,
                      vecs[i].ign_at, vecs[i].exp_n, vecs[i].exp_cycles);

        // Reset in the middle of an 8-word frame after two words.
        @(negedge clk);
        base_addr   = AW'(200);
        frame_words = (AW+1)'(8);
        start       = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        for (int c = 1; c <= 4; c++) begin
            if (out_valid && out_ready) begin
                chk("rst_frame_data", {16'd0, out_data},
                    {16'd0, ram[200 + got]});
                got++;
            end
            @(negedge clk);
        end
        chk("rst_frame_words", 32'(got), 32'd2);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        run_frame(0, 1, 100, 0, 1, 4);

        for (int r = 0; r < 10; r++) begin
            int b, w, p, n;
            b = $urandom_range(DEPTH - 1);
            w = $urandom_range(40);
            p = $urandom_range(100, 10);
            n = (w == 0) ? 1 : w;
            run_frame(b, w, p, 0, n, (p == 100) ? n + 3 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
# frame_reader

Streaming reader for the read-only port (port B) of the 16-bit dual-port RAM. On a `start` pulse it fetches `frame_words` consecutive words from `base_addr` and presents them on a valid/ready stream. It tracks the RAM's one-cycle registered read latency and buffers words in a small FIFO, so a stalling consumer (video/scanline logic) never loses data. Port A (CPU side) is not touched.

## Interface

- `DEPTH`, 16384, RAM depth in 16-bit words; must be a power of two.
- `ADDRESS_WIDTH`, `$clog2(DEPTH)`, RAM address width.
- `FIFO_DEPTH`, 4, output buffer depth in words; power of two, ≥2.
- `clk` in 1 — single clock, shared with the RAM.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle pulse that begins a frame; ignored while `busy`.
- `base_addr` in ADDRESS_WIDTH — first word address; sampled with `start`.
- `frame_words` in ADDRESS_WIDTH+1 — word count, 1..DEPTH; sampled with `start`; 0 is treated as 1.
- `addr_b` out ADDRESS_WIDTH — RAM port B address.
- `q_b` in 16 — RAM port B data, valid one cycle after `addr_b`.
- `out_valid` out 1 — `out_data` is valid.
- `out_ready` in 1 — consumer accepts the word.
- `out_data` out 16 — word stream.
- `out_last` out 1 — marks the final word of the frame; qualified by `out_valid`.
- `busy` out 1 — high from the cycle after `start` until the last word is accepted.

## Operation

- **States:**
  - IDLE: wait for `start`.
  - FETCH: issue reads.
  - DRAIN: all reads issued; wait for FIFO empty and last word accepted.
- **IDLE → FETCH** on `start`. Latch `base_addr` into the address counter and `frame_words` into the remaining counter.
- **Issuing reads (FETCH):** a read issues in a cycle when credit = FIFO_DEPTH − fifo_count − inflight > 0. Here inflight (0/1) is a registered flag meaning "read issued last cycle".
  - On issue, `addr_b` = address counter for that cycle; the counter increments and remaining decrements.
  - Address arithmetic is modulo DEPTH: wraps from DEPTH−1 to 0.
- **Capture:** `q_b` is written into the FIFO only in the cycle after an issue (inflight=1). It is ignored otherwise, because port B updates every cycle.
- Each FIFO entry carries a last bit, set on the entry for the final issued address.
- **FETCH → DRAIN** when the final read issues. **DRAIN → IDLE** when the entry with last=1 is popped (`out_valid & out_ready & out_last`).
- A `start` received while not IDLE is ignored: no restart, no queueing.
- Simultaneous FIFO push and pop is allowed and leaves the count unchanged. A push is never attempted while full, which the credit rule guarantees.
- `addr_b` holds its last value when no read issues; port B reads have no side effects.
- `rst` mid-frame: return to IDLE next cycle, flush the FIFO, clear inflight, drop the frame.

## Timing

- **Reset values:** `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0, `addr_b`=0, state=IDLE, fifo_count=0.
- **Startup latency:** `start` sampled at edge 0; `addr_b`=base in cycle 1; `q_b` valid in cycle 2 and pushed at edge 2; `out_valid`=1 in cycle 3. Start to first word is 3 cycles.
- **Throughput:** one word per cycle sustained while `out_ready`=1.
- **Stall:** `out_ready` low fills the FIFO after at most FIFO_DEPTH words; issue stops with no loss or duplication.
- **Output rules:** `out_data`/`out_last` are stable while `out_valid & ~out_ready`, and `out_valid` never drops without a handshake.
- **`busy`** rises the cycle after `start` and falls the cycle after the last handshake. A new `start` is accepted in the cycle `busy` is low.

## Structure

- Word width (16) and byte-lane count (2) are constants in the shared RAM package. State encoding is local to this block.
- One sub-module: `sync_fifo` (parameters width, depth).
  - Interface: push, pop, full, empty, count; registered outputs, first-word-fall-through.
  - Instantiated with width 17: data plus last.

## Test plan

- **Basic frame:** reset, preload RAM[100..103]=0xA000..0xA003; start base=100, words=4, `out_ready`=1. Expect out 0xA000..0xA003 in cycles 3–6, `out_last` only on 0xA003, `busy` low at cycle 7.
- **Wrap:** base=DEPTH−2, words=4. Expect addresses DEPTH−2, DEPTH−1, 0, 1 issued and data in that order.
- **Backpressure:** words=16, `out_ready` toggling pseudo-randomly at 30% high. Expect all 16 words in order, no duplicates, at most FIFO_DEPTH words buffered, `out_data` stable during stalls.
- **Ignored start:** second `start` with base=500 mid-frame. Expect original frame unaffected and no reads at 500.
- **Reset mid-frame:** assert `rst` after 2 words accepted from an 8-word frame. Expect next cycle `out_valid`=0, `busy`=0; a new frame base=0, words=1 then completes normally.
- **Single/zero length:** words=1 and words=0. Each yields exactly one word with `out_last`=1.
